// File: rtl/fir_pkg.sv
// Shared constants for the 2x polyphase FIR interpolator: sample width,
// default prototype taps and FSM state encoding.
package fir_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int NUM_TAPS  = 16;
    localparam int HIST_LEN  = 8;

    localparam logic signed [15:0] B_DEF [NUM_TAPS] = '{
        16'hFDDD, 16'hFFF6, 16'h02EB, 16'h0671, 16'h0A1B, 16'h0D6E, 16'h0FF5, 16'h1152,
        16'h1152, 16'h0FF5, 16'h0D6E, 16'h0A1B, 16'h0671, 16'h02EB, 16'hFFF6, 16'hFDDD
    };

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MAC0 = 3'd1,
        OUT0 = 3'd2,
        MAC1 = 3'd3,
        OUT1 = 3'd4
    } fir_state_e;

endpackage

// File: rtl/fir_interp2_mac.sv
// Signed multiply-accumulate with synchronous clear; clear wins over enable.
module fir_interp2_mac
    import fir_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_clr,
    input  logic                      i_en,
    input  logic signed [WIDTH-1:0]   i_a,
    input  logic signed [WIDTH-1:0]   i_b,
    output logic signed [2*WIDTH-1:0] o_acc
);

    logic signed [2*WIDTH-1:0] acc_q, acc_d, prod;

    always_comb begin
        prod  = $signed({{WIDTH{i_a[WIDTH-1]}}, i_a}) * $signed({{WIDTH{i_b[WIDTH-1]}}, i_b});
        acc_d = acc_q;
        if (i_clr) begin
            acc_d = '0;
        end else if (i_en) begin
            acc_d = acc_q + prod;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign o_acc = acc_q;

endmodule

// File: rtl/fir_interp2.sv
// 2x polyphase interpolator: each accepted sample yields an even-phase then an
// odd-phase output, each built from 8 sequential MACs over the sample history.
module fir_interp2
    import fir_pkg::*;
#(
    parameter int                       WIDTH = WIDTH_DEF,
    parameter logic signed [WIDTH-1:0]  B0  = B_DEF[0],
    parameter logic signed [WIDTH-1:0]  B1  = B_DEF[1],
    parameter logic signed [WIDTH-1:0]  B2  = B_DEF[2],
    parameter logic signed [WIDTH-1:0]  B3  = B_DEF[3],
    parameter logic signed [WIDTH-1:0]  B4  = B_DEF[4],
    parameter logic signed [WIDTH-1:0]  B5  = B_DEF[5],
    parameter logic signed [WIDTH-1:0]  B6  = B_DEF[6],
    parameter logic signed [WIDTH-1:0]  B7  = B_DEF[7],
    parameter logic signed [WIDTH-1:0]  B8  = B_DEF[8],
    parameter logic signed [WIDTH-1:0]  B9  = B_DEF[9],
    parameter logic signed [WIDTH-1:0]  B10 = B_DEF[10],
    parameter logic signed [WIDTH-1:0]  B11 = B_DEF[11],
    parameter logic signed [WIDTH-1:0]  B12 = B_DEF[12],
    parameter logic signed [WIDTH-1:0]  B13 = B_DEF[13],
    parameter logic signed [WIDTH-1:0]  B14 = B_DEF[14],
    parameter logic signed [WIDTH-1:0]  B15 = B_DEF[15]
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic signed [WIDTH-1:0]   i_signal,
    input  logic                      i_in_valid,
    output logic                      o_in_ready,
    output logic signed [2*WIDTH-1:0] o_signal,
    output logic                      o_out_valid,
    input  logic                      i_out_ready
);

    localparam logic signed [WIDTH-1:0] TAPS [NUM_TAPS] = '{
        B0, B1, B2, B3, B4, B5, B6, B7, B8, B9, B10, B11, B12, B13, B14, B15
    };

    fir_state_e                state_q, state_d;
    logic [2:0]                ptr_q, ptr_d, tap_q, tap_d, rd_idx;
    logic signed [WIDTH-1:0]   hist_q [HIST_LEN];
    logic signed [WIDTH-1:0]   hist_d [HIST_LEN];
    logic signed [2*WIDTH-1:0] sig_q, sig_d, acc;
    logic                      vld_q, vld_d, mac_clr, mac_en, phase;
    logic signed [WIDTH-1:0]   coef, samp;

    always_comb begin
        // Newest sample sits just behind the write pointer; tap k reaches k samples back.
        phase   = (state_q == MAC1);
        rd_idx  = ptr_q - 3'd1 - tap_q;
        coef    = TAPS[{tap_q, phase}];
        samp    = hist_q[rd_idx];
        state_d = state_q;
        ptr_d   = ptr_q;
        tap_d   = tap_q;
        hist_d  = hist_q;
        sig_d   = sig_q;
        vld_d   = vld_q;
        mac_clr = 1'b0;
        mac_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_in_valid) begin
                    hist_d[ptr_q] = i_signal;
                    ptr_d         = ptr_q + 3'd1;
                    tap_d         = 3'd0;
                    mac_clr       = 1'b1;
                    state_d       = MAC0;
                end
            end
            MAC0, MAC1: begin
                mac_en = 1'b1;
                tap_d  = tap_q + 3'd1;
                if (tap_q == 3'd7) begin
                    state_d = (state_q == MAC0) ? OUT0 : OUT1;
                end
            end
            OUT0, OUT1: begin
                // First OUT cycle captures the finished sum; valid is presented from the next.
                if (!vld_q) begin
                    vld_d = 1'b1;
                    sig_d = acc;
                end else if (i_out_ready) begin
                    vld_d = 1'b0;
                    if (state_q == OUT0) begin
                        mac_clr = 1'b1;
                        state_d = MAC1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            tap_q   <= '0;
            sig_q   <= '0;
            vld_q   <= 1'b0;
            for (int i = 0; i < HIST_LEN; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            tap_q   <= tap_d;
            sig_q   <= sig_d;
            vld_q   <= vld_d;
            hist_q  <= hist_d;
        end
    end

    fir_interp2_mac #(.WIDTH(WIDTH)) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (mac_clr),
        .i_en  (mac_en),
        .i_a   (coef),
        .i_b   (samp),
        .o_acc (acc)
    );

    assign o_in_ready  = (state_q == IDLE);
    assign o_out_valid = vld_q;
    assign o_signal    = sig_q;

endmodule

// File: tb/tb_fir_interp2.sv
// Directed bench for fir_interp2: a convolution model fills an expected-value
// queue per accepted sample; outputs are popped and compared on each handshake.
module tb_fir_interp2;

    localparam int W = 16;

    logic                  clk, rst_n;
    logic signed [W-1:0]   i_signal;
    logic                  i_in_valid, o_in_ready, o_out_valid, i_out_ready;
    logic signed [2*W-1:0] o_signal;

    int          n_chk, n_pass;
    int          mh [8];
    logic [31:0] exp_q [$];
    logic [31:0] last_y [2];
    int          h_tab [16] = '{-547, -10, 747, 1649, 2587, 3438, 4085, 4434,
                                4434, 4085, 3438, 2587, 1649, 747, -10, -547};

    fir_interp2 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_signal    (i_signal),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .o_signal    (o_signal),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: got %0d (0x%08h) want %0d (0x%08h)", tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 8; k++) mh[k] = 0;
        exp_q.delete();
    endtask

    task automatic model_push(input int x);
        longint y0, y1;
        for (int k = 7; k > 0; k--) mh[k] = mh[k-1];
        mh[0] = x;
        y0 = 0;
        y1 = 0;
        for (int k = 0; k < 8; k++) begin
            y0 += longint'(h_tab[2*k])   * longint'(mh[k]);
            y1 += longint'(h_tab[2*k+1]) * longint'(mh[k]);
        end
        exp_q.push_back(32'(y0));
        exp_q.push_back(32'(y1));
    endtask

    // Drive one sample, then collect both phases. A nonzero stall holds
    // i_out_ready low for that many cycles in OUT0 and pokes i_in_valid.
    task automatic send(input int x, input int stall);
        int          c;
        logic [31:0] held, exp;
        c = 0;
        while (!o_in_ready && c < 60) begin
            @(posedge clk); #1; c++;
        end
        check("in_ready_wait", 32'(o_in_ready), 32'd1);
        model_push(x);
        i_signal    = W'(x);
        i_in_valid  = 1'b1;
        i_out_ready = (stall == 0);
        @(posedge clk); #1;
        i_in_valid = 1'b0;
        for (int p = 0; p < 2; p++) begin
            c = 0;
            while (!o_out_valid && c < 40) begin
                @(posedge clk); #1; c++;
            end
            check(p == 0 ? "latency_ph0" : "latency_ph1", 32'(c), 32'd9);
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            if (p == 0 && stall > 0) begin
                held = o_signal;
                for (int s = 0; s < stall; s++) begin
                    i_in_valid = (s == 1);
                    i_signal   = 16'sh7FFF;
                    @(posedge clk); #1;
                    check("bp_valid_held", 32'(o_out_valid), 32'd1);
                    check("bp_data_stable", o_signal, held);
                    check("bp_in_ready_low", 32'(o_in_ready), 32'd0);
                end
                i_in_valid  = 1'b0;
                i_out_ready = 1'b1;
            end
            check(p == 0 ? "y_even" : "y_odd", o_signal, exp);
            last_y[p] = o_signal;
            @(posedge clk); #1;
        end
        check("in_ready_after_ph1", 32'(o_in_ready), 32'd1);
        check("valid_drop_after_ph1", 32'(o_out_valid), 32'd0);
    endtask

    initial begin
        int c;
        logic seen;
        n_chk       = 0;
        n_pass      = 0;
        rst_n       = 1'b0;
        i_signal    = '0;
        i_in_valid  = 1'b0;
        i_out_ready = 1'b1;
        model_clear();

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(o_in_ready), 32'd1);
        check("rst_out_valid", 32'(o_out_valid), 32'd0);
        check("rst_signal", o_signal, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", 32'(o_in_ready), 32'd1);

        // Impulse response, including history wrap and return to zero
        send(1, 0);
        check("impulse_h0", last_y[0], 32'hFFFF_FDDD);
        check("impulse_h1", last_y[1], 32'hFFFF_FFF6);
        for (int i = 0; i < 9; i++) send(0, 0);
        check("impulse_tail_zero", last_y[1], 32'd0);

        // DC gain
        for (int i = 0; i < 10; i++) send(1, 0);
        check("dc_even", last_y[0], 32'd16383);
        check("dc_odd", last_y[1], 32'd16383);

        // Backpressure; the sample after proves the poked input was not stored
        send(5, 5);
        send(-3, 0);
        for (int i = 0; i < 6; i++) send(int'($signed(16'($urandom_range(0, 65535)))), 0);

        // Reset while in MAC1 after an impulse
        model_clear();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        i_signal   = 16'sd1;
        i_in_valid = 1'b1;
        @(posedge clk); #1;
        i_in_valid = 1'b0;
        c = 0;
        while (!o_out_valid && c < 40) begin
            @(posedge clk); #1; c++;
        end
        check("mid_rst_ph0", o_signal, 32'hFFFF_FDDD);
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(o_out_valid), 32'd0);
        check("mid_rst_signal", o_signal, 32'd0);
        check("mid_rst_in_ready", 32'(o_in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            if (o_out_valid) seen = 1'b1;
        end
        check("mid_rst_no_output", 32'(seen), 32'd0);
        send(1, 0);
        check("post_rst_impulse_h0", last_y[0], 32'hFFFF_FDDD);
        check("post_rst_impulse_h1", last_y[1], 32'hFFFF_FFF6);
        send(0, 0);

        // Negative full scale, steady state
        for (int i = 0; i < 9; i++) send(-32768, 0);
        check("negfs_even", last_y[0], 32'(-536838144));
        check("negfs_odd", last_y[1], 32'(-536838144));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fir_interp2.md
FIR_INTERP2 -- requirements
Module: fir_interp2

Interface
REQ-001 Parameter WIDTH, default 16, sample width; outputs are 2*WIDTH wide.
REQ-002 Parameters B0..B15, defaults 16'hFDDD, 16'hFFF6, 16'h02EB, 16'h0671, 16'h0A1B, 16'h0D6E, 16'h0FF5, 16'h1152, 16'h1152, 16'h0FF5, 16'h0D6E, 16'h0A1B, 16'h0671, 16'h02EB, 16'hFFF6, 16'hFDDD; signed prototype taps h[0..15].
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_signal  input  WIDTH  signed input sample x[m].
REQ-006 i_in_valid  input  1  i_signal valid.
REQ-007 o_in_ready  output  1  block accepts a sample this cycle.
REQ-008 o_signal  output  2*WIDTH  signed interpolated output y[n].
REQ-009 o_out_valid  output  1  o_signal valid.
REQ-010 i_out_ready  input  1  downstream accepts o_signal.

Function
REQ-011 Block SHALL be a 2x polyphase interpolator: y[2m] = sum(k=0..7) h[2k]*x[m-k]; y[2m+1] = sum(k=0..7) h[2k+1]*x[m-k].
REQ-012 Arithmetic SHALL be two's-complement signed; products 2*WIDTH bits; accumulation modulo 2^(2*WIDTH) (default taps cannot overflow).
REQ-013 History SHALL be an 8-entry circular buffer with write pointer wrapping 7->0; x[m-k] for k>m reads zero after reset.
REQ-014 FSM states: IDLE, MAC0, OUT0, MAC1, OUT1.
REQ-015 IDLE: o_in_ready=1; on i_in_valid&&o_in_ready the sample is written, pointer advances, accumulator clears, go MAC0.
REQ-016 MAC0/MAC1: exactly 8 cycles, one tap-product per cycle, tap counter 0..7, then OUT0/OUT1.
REQ-017 OUT0/OUT1: o_out_valid=1, o_signal registered and held stable until i_out_ready; on handshake OUT0->MAC1, OUT1->IDLE.
REQ-018 o_in_ready SHALL be 0 in every state except IDLE; i_in_valid outside IDLE is ignored and the sample is not stored.
REQ-019 Latency: o_out_valid rises 9 cycles after the input acceptance edge; phase-1 o_out_valid rises 9 cycles after phase-0 handshake; o_in_ready rises the cycle after phase-1 handshake.
REQ-020 With i_out_ready tied high, throughput SHALL be one input per 21 cycles, two outputs per input.
REQ-021 o_signal SHALL retain its last value when o_out_valid=0.

Reset
REQ-022 Asserting rst_n low SHALL immediately force state IDLE, history all zero, pointer 0, tap counter 0, accumulator 0, o_signal 0, o_out_valid 0.
REQ-023 o_in_ready SHALL be 1 from reset release onward until a sample is accepted.
REQ-024 Reset mid-MAC or mid-OUT SHALL discard the partial/pending result; no output is produced for that sample.

Structure
REQ-025 Shared package fir_pkg SHALL hold WIDTH default, default tap constants, and the FSM state encoding.
REQ-026 One sub-module fir_interp2_mac (signed multiply + accumulate, clear and enable inputs) SHALL be instantiated once.

Verification
REQ-027 Impulse: x=1 then zeros, i_out_ready=1 -> outputs -547, -10, 747, 1649, 2587, 3438, 4085, 4434, 4434, 4085, ..., -10, -547, then zeros.
REQ-028 DC: x=1 for 10 samples -> from 8th input onward every output = 16383 (even and odd phases).
REQ-029 Backpressure: i_out_ready low 5 cycles in OUT0 -> o_signal stable, o_out_valid held 1, o_in_ready 0, i_in_valid pulse ignored.
REQ-030 Timing: accept at edge E -> o_out_valid first high at E+9; o_in_ready high the cycle after second handshake.
REQ-031 Reset mid-MAC1 after x=1 -> o_out_valid 0, o_signal 0, o_in_ready 1; next impulse reproduces REQ-027 from -547.
REQ-032 Negative full scale: x=-32768 constant -> steady outputs -536838144 on both phases.
